// File: rtl/tl_a_rr_arbiter_if.sv
// TileLink A-channel bundle between N requesters and the arbiter.
// The slave modport is the arbiter's view and the master modport is the environment's view.
interface tl_a_rr_arbiter_if #(
  parameter int N      = 4,
  parameter int SIZE_W = 3,
  parameter int SRC_W  = 10,
  parameter int ADDR_W = 33
);
  localparam int GW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]        io_in_valid;
  logic [N-1:0]        io_in_ready;
  logic [N*3-1:0]      io_in_bits_opcode;
  logic [N*3-1:0]      io_in_bits_param;
  logic [N*SIZE_W-1:0] io_in_bits_size;
  logic [N*SRC_W-1:0]  io_in_bits_source;
  logic [N*ADDR_W-1:0] io_in_bits_address;
  logic [N*8-1:0]      io_in_bits_mask;
  logic [N*64-1:0]     io_in_bits_data;

  logic                io_out_valid;
  logic                io_out_ready;
  logic [2:0]          io_out_bits_opcode;
  logic [2:0]          io_out_bits_param;
  logic [SIZE_W-1:0]   io_out_bits_size;
  logic [SRC_W-1:0]    io_out_bits_source;
  logic [ADDR_W-1:0]   io_out_bits_address;
  logic [7:0]          io_out_bits_mask;
  logic [63:0]         io_out_bits_data;
  logic [GW-1:0]       io_out_grant;
  logic                io_out_locked;

  modport slave (
    input  io_in_valid, io_in_bits_opcode, io_in_bits_param, io_in_bits_size,
           io_in_bits_source, io_in_bits_address, io_in_bits_mask, io_in_bits_data,
           io_out_ready,
    output io_in_ready, io_out_valid, io_out_bits_opcode, io_out_bits_param,
           io_out_bits_size, io_out_bits_source, io_out_bits_address,
           io_out_bits_mask, io_out_bits_data, io_out_grant, io_out_locked
  );

  modport master (
    output io_in_valid, io_in_bits_opcode, io_in_bits_param, io_in_bits_size,
           io_in_bits_source, io_in_bits_address, io_in_bits_mask, io_in_bits_data,
           io_out_ready,
    input  io_in_ready, io_out_valid, io_out_bits_opcode, io_out_bits_param,
           io_out_bits_size, io_out_bits_source, io_out_bits_address,
           io_out_bits_mask, io_out_bits_data, io_out_grant, io_out_locked
  );
endinterface

// File: rtl/tl_a_rr_arbiter.sv
// Round-robin TileLink A-channel arbiter with Put-burst locking and a zero-latency output mux.
// Defining TL_ARB_PERF_EN adds io_perf_stall, which holds a saturating stall counter for each requester.
module tl_a_rr_arbiter #(
  parameter int N        = 4,
  parameter int SIZE_W   = 3,
  parameter int SRC_W    = 10,
  parameter int ADDR_W   = 33,
  parameter int BEAT_LG2 = 3
) (
  input  logic clock,
  input  logic reset,
  tl_a_rr_arbiter_if.slave bus
`ifdef TL_ARB_PERF_EN
  ,
  output logic [N*16-1:0] io_perf_stall
`endif
);
  localparam int GW       = (N > 1) ? $clog2(N) : 1;
  localparam int SPAN_MAX = (1 << SIZE_W) - 1 - BEAT_LG2;
  // The counter must be wide enough to hold the beat count of the largest legal burst.
  localparam int BL_W     = (SPAN_MAX > SIZE_W) ? SPAN_MAX : SIZE_W;

  logic [GW-1:0]   last_ptr;
  logic [GW-1:0]   held_idx;
  logic            locked;
  logic            hold;
  logic [BL_W-1:0] beats_left;

  logic [GW-1:0]   rr_idx;
  logic            rr_found;
  logic [GW-1:0]   cand;
  logic [GW-1:0]   sel;
  int              sel_i;
  int              span;
  logic            out_valid;
  logic            fire;
  logic            start_burst;
  logic [BL_W-1:0] beats_init;
  logic [N-1:0]    ready_vec;

  logic [2:0]        m_opcode;
  logic [2:0]        m_param;
  logic [SIZE_W-1:0] m_size;
  logic [SRC_W-1:0]  m_source;
  logic [ADDR_W-1:0] m_address;
  logic [7:0]        m_mask;
  logic [63:0]       m_data;

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = 1; k <= N; k++) begin
      cand = GW'((int'(last_ptr) + k) % N);
      if (!rr_found && bus.io_in_valid[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  always_comb begin
    sel       = (locked || hold) ? held_idx : rr_idx;
    sel_i     = int'(sel);
    m_opcode  = bus.io_in_bits_opcode[sel_i*3 +: 3];
    m_param   = bus.io_in_bits_param[sel_i*3 +: 3];
    m_size    = bus.io_in_bits_size[sel_i*SIZE_W +: SIZE_W];
    m_source  = bus.io_in_bits_source[sel_i*SRC_W +: SRC_W];
    m_address = bus.io_in_bits_address[sel_i*ADDR_W +: ADDR_W];
    m_mask    = bus.io_in_bits_mask[sel_i*8 +: 8];
    m_data    = bus.io_in_bits_data[sel_i*64 +: 64];
  end

  always_comb begin
    out_valid = reset && (locked || hold || rr_found) && bus.io_in_valid[sel];
    fire      = out_valid && bus.io_out_ready;
    ready_vec = '0;
    if (fire) ready_vec[sel] = 1'b1;
    span       = int'(m_size) - BEAT_LG2;
    beats_init = '0;
    if (span > 0 && span < 31) beats_init = BL_W'((1 << span) - 1);
    start_burst = fire && !locked && (m_opcode == 3'd0 || m_opcode == 3'd1) && (span > 0);
  end

  // While reset is asserted every output is forced to zero, including the muxed bits.
  always_comb begin
    bus.io_out_valid        = out_valid;
    bus.io_in_ready         = ready_vec;
    bus.io_out_grant        = '0;
    bus.io_out_bits_opcode  = '0;
    bus.io_out_bits_param   = '0;
    bus.io_out_bits_size    = '0;
    bus.io_out_bits_source  = '0;
    bus.io_out_bits_address = '0;
    bus.io_out_bits_mask    = '0;
    bus.io_out_bits_data    = '0;
    if (reset) begin
      bus.io_out_grant        = sel;
      bus.io_out_bits_opcode  = m_opcode;
      bus.io_out_bits_param   = m_param;
      bus.io_out_bits_size    = m_size;
      bus.io_out_bits_source  = m_source;
      bus.io_out_bits_address = m_address;
      bus.io_out_bits_mask    = m_mask;
      bus.io_out_bits_data    = m_data;
    end
  end

  assign bus.io_out_locked = locked;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_ptr   <= GW'(N - 1);
      held_idx   <= '0;
      locked     <= 1'b0;
      hold       <= 1'b0;
      beats_left <= '0;
    end else begin
      if (fire) begin
        hold <= 1'b0;
      end else if (out_valid) begin
        hold     <= 1'b1;
        held_idx <= sel;
      end
      if (start_burst) begin
        locked     <= 1'b1;
        held_idx   <= sel;
        beats_left <= beats_init;
      end else if (fire && locked) begin
        beats_left <= beats_left - 1'b1;
        if (beats_left == BL_W'(1)) begin
          locked   <= 1'b0;
          last_ptr <= sel;
        end
      end else if (fire) begin
        last_ptr <= sel;
      end
    end
  end

`ifdef TL_ARB_PERF_EN
  logic [15:0] stall_cnt [N];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) stall_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (bus.io_in_valid[i] && !ready_vec[i] && stall_cnt[i] != 16'hFFFF)
          stall_cnt[i] <= stall_cnt[i] + 16'd1;
    end
  end

  always_comb begin
    io_perf_stall = '0;
    for (int i = 0; i < N; i++) io_perf_stall[i*16 +: 16] = stall_cnt[i];
  end
`endif
endmodule

// File: tb/tb_tl_a_rr_arbiter.sv
// Directed bench for tl_a_rr_arbiter: a table of single-beat vectors, then hand-built
// sequences for stall/hold, single requester, 8-beat burst, reset mid-burst, and the optional perf counter.
module tb_tl_a_rr_arbiter;
  localparam int N = 4, SIZE_W = 3, SRC_W = 10, ADDR_W = 33, BEAT_LG2 = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  tl_a_rr_arbiter_if #(.N(N), .SIZE_W(SIZE_W), .SRC_W(SRC_W), .ADDR_W(ADDR_W)) bus ();

`ifdef TL_ARB_PERF_EN
  logic [N*16-1:0] perf_stall;
`endif

  tl_a_rr_arbiter #(.N(N), .SIZE_W(SIZE_W), .SRC_W(SRC_W), .ADDR_W(ADDR_W), .BEAT_LG2(BEAT_LG2)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
`ifdef TL_ARB_PERF_EN
    ,
    .io_perf_stall(perf_stall)
`endif
  );

  typedef struct {
    logic [3:0] valid;
    logic       ordy;
    logic       ev;
    int         eg;
    logic [3:0] erdy;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc_check(input string tag, input logic ev, input int eg,
                           input logic [3:0] erdy, input logic elk);
    chk({tag, "_valid"}, 64'(bus.io_out_valid), 64'(ev));
    chk({tag, "_grant"}, 64'(bus.io_out_grant), 64'(eg));
    chk({tag, "_ready"}, 64'(bus.io_in_ready), 64'(erdy));
    chk({tag, "_locked"}, 64'(bus.io_out_locked), 64'(elk));
    if (ev) begin
      chk({tag, "_source"}, 64'(bus.io_out_bits_source), 64'(SRC_W'(256 + eg)));
      chk({tag, "_addr"}, 64'(bus.io_out_bits_address), 64'(33'h1_0000_0000 + 33'(eg << 8)));
      chk({tag, "_data"}, bus.io_out_bits_data, 64'hA5A5_0000_0000_0000 | 64'(eg));
    end
  endtask

  // Called at a falling edge: drive inputs, check the combinational response, then advance one cycle.
  task automatic drive_chk(input logic [3:0] valid, input logic ordy, input string tag,
                           input logic ev, input int eg, input logic [3:0] erdy, input logic elk);
    bus.io_in_valid  = valid;
    bus.io_out_ready = ordy;
    #1;
    cyc_check(tag, ev, eg, erdy, elk);
    @(negedge clock);
  endtask

  task automatic set_op(input int i, input logic [2:0] op, input logic [SIZE_W-1:0] sz);
    bus.io_in_bits_opcode[i*3 +: 3]        = op;
    bus.io_in_bits_size[i*SIZE_W +: SIZE_W] = sz;
  endtask

  initial begin
    vecs[0]  = '{4'b0000, 1'b1, 1'b0, 0, 4'b0000};
    vecs[1]  = '{4'b1111, 1'b1, 1'b1, 0, 4'b0001};
    vecs[2]  = '{4'b1111, 1'b1, 1'b1, 1, 4'b0010};
    vecs[3]  = '{4'b1111, 1'b1, 1'b1, 2, 4'b0100};
    vecs[4]  = '{4'b1111, 1'b1, 1'b1, 3, 4'b1000};
    vecs[5]  = '{4'b1111, 1'b1, 1'b1, 0, 4'b0001};
    vecs[6]  = '{4'b1010, 1'b1, 1'b1, 1, 4'b0010};
    vecs[7]  = '{4'b1010, 1'b1, 1'b1, 3, 4'b1000};
    vecs[8]  = '{4'b1010, 1'b0, 1'b1, 1, 4'b0000};
    vecs[9]  = '{4'b1110, 1'b0, 1'b1, 1, 4'b0000};
    vecs[10] = '{4'b1110, 1'b1, 1'b1, 1, 4'b0010};
    vecs[11] = '{4'b1100, 1'b1, 1'b1, 2, 4'b0100};
    vecs[12] = '{4'b0001, 1'b1, 1'b1, 0, 4'b0001};
    vecs[13] = '{4'b0001, 1'b1, 1'b1, 0, 4'b0001};
    vecs[14] = '{4'b0100, 1'b0, 1'b1, 2, 4'b0000};
    vecs[15] = '{4'b1111, 1'b1, 1'b1, 2, 4'b0100};
    vecs[16] = '{4'b1111, 1'b1, 1'b1, 3, 4'b1000};

    for (int i = 0; i < N; i++) begin
      bus.io_in_bits_opcode[i*3 +: 3]           = 3'd4;
      bus.io_in_bits_param[i*3 +: 3]            = 3'd0;
      bus.io_in_bits_size[i*SIZE_W +: SIZE_W]   = SIZE_W'(3);
      bus.io_in_bits_source[i*SRC_W +: SRC_W]   = SRC_W'(256 + i);
      bus.io_in_bits_address[i*ADDR_W +: ADDR_W] = 33'h1_0000_0000 + 33'(i << 8);
      bus.io_in_bits_mask[i*8 +: 8]             = 8'hFF;
      bus.io_in_bits_data[i*64 +: 64]           = 64'hA5A5_0000_0000_0000 | 64'(i);
    end
    bus.io_in_valid  = 4'b1111;
    bus.io_out_ready = 1'b1;
    reset = 1'b0;

    // Outputs must stay zero while reset is held, even with every requester valid.
    @(negedge clock);
    #1;
    cyc_check("rst", 1'b0, 0, 4'b0000, 1'b0);
    chk("rst_source", 64'(bus.io_out_bits_source), 64'd0);
    chk("rst_data", bus.io_out_bits_data, 64'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 17; i++)
      drive_chk(vecs[i].valid, vecs[i].ordy, $sformatf("vec%0d", i),
                vecs[i].ev, vecs[i].eg, vecs[i].erdy, 1'b0);

    // Stall: req0 is blocked for 5 cycles and the grant holds when req3 arrives.
    for (int c = 1; c <= 5; c++)
      drive_chk((c >= 3) ? 4'b1001 : 4'b0001, 1'b0, $sformatf("stall%0d", c),
                1'b1, 0, 4'b0000, 1'b0);
    drive_chk(4'b1001, 1'b1, "stall_fire", 1'b1, 0, 4'b0001, 1'b0);
    drive_chk(4'b1000, 1'b1, "stall_next", 1'b1, 3, 4'b1000, 1'b0);

    // A single requester fires on every cycle.
    for (int c = 0; c < 4; c++)
      drive_chk(4'b0100, 1'b1, $sformatf("solo%0d", c), 1'b1, 2, 4'b0100, 1'b0);

    // 8-beat PutFull from req1, with a one-cycle valid gap after beat 3.
    set_op(1, 3'd0, SIZE_W'(6));
    for (int b = 1; b <= 8; b++) begin
      drive_chk(4'b0110, 1'b1, $sformatf("burst_b%0d", b), 1'b1, 1, 4'b0010, (b > 1));
      if (b == 3)
        drive_chk(4'b0100, 1'b1, "burst_gap", 1'b0, 1, 4'b0000, 1'b1);
    end
    drive_chk(4'b0110, 1'b1, "burst_after", 1'b1, 2, 4'b0100, 1'b0);

    // Reset is asserted after beat 3 of another req1 burst.
    drive_chk(4'b0010, 1'b1, "rb_b1", 1'b1, 1, 4'b0010, 1'b0);
    drive_chk(4'b0011, 1'b1, "rb_b2", 1'b1, 1, 4'b0010, 1'b1);
    drive_chk(4'b0011, 1'b1, "rb_b3", 1'b1, 1, 4'b0010, 1'b1);
    reset = 1'b0;
    #1;
    cyc_check("rb_rst", 1'b0, 0, 4'b0000, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    drive_chk(4'b0011, 1'b1, "rb_rel", 1'b1, 0, 4'b0001, 1'b0);

`ifdef TL_ARB_PERF_EN
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    bus.io_in_valid  = 4'b1000;
    bus.io_out_ready = 1'b0;
    repeat (70000) @(negedge clock);
    chk("perf_req3", 64'(perf_stall[63:48]), 64'hFFFF);
    chk("perf_others", 64'(perf_stall[47:0]), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
